vga_timing_gen: RTL

Free-running 1024x768 @ 60 Hz (65 MHz pixel clock) VGA timing generator. It produces the raster coordinates, sync pulses and blanking strobes consumed by the background, sprite and overlay drawing stages downstream. It also emits per-frame and per-line markers and a frame counter for game logic that must update once per frame.

---
 rtl/vga_pkg.sv | 39 +++
 rtl/vga_axis_counter.sv | 46 ++++
 rtl/vga_timing_gen.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 1024x768@60 VGA timing constants
// Purpose: default raster timing, derived sync windows, screen-edge constants
//          and coordinate width shared by the timing generator and the
//          downstream drawing stages.
// Ports:   none (package)
package vga_pkg;

  localparam int COORD_W  = 12;

  localparam int H_ACTIVE = 1024;
  localparam int H_FP     = 24;
  localparam int H_SYNC   = 136;
  localparam int H_BP     = 160;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;   // 1344

  localparam int V_ACTIVE = 768;
  localparam int V_FP     = 3;
  localparam int V_SYNC   = 6;
  localparam int V_BP     = 29;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;   // 806

  // Sync windows are half-open: [start, end).
  localparam int H_SYNC_START = H_ACTIVE + H_FP;              // 1048
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;        // 1184
  localparam int V_SYNC_START = V_ACTIVE + V_FP;              // 771
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;        // 777

  // Last visible column/row, used by drawing stages for edge clipping.
  localparam int H_LAST_VISIBLE = H_ACTIVE - 1;               // 1023
  localparam int V_LAST_VISIBLE = V_ACTIVE - 1;               // 767

  // True when coordinate c lies in the half-open window [lo, hi).
  function automatic logic in_window(input logic [COORD_W-1:0] c,
                                     input int                 lo,
                                     input int                 hi);
    return (c >= COORD_W'(lo)) && (c < COORD_W'(hi));
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - enabled wrap counter for one raster axis
// Purpose: counts 0..TOTAL-1 on enabled cycles and wraps to 0.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   en          advance this cycle
//   count       registered current value
//   count_next  value the counter will hold after this edge (combinational)
//   wrap        high on the enabled cycle that moves TOTAL-1 -> 0
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = H_TOTAL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [COORD_W-1:0] count,
  output logic [COORD_W-1:0] count_next,
  output logic               wrap
);

  logic [COORD_W-1:0] count_q;
  logic [COORD_W-1:0] count_d;
  logic               at_last;

  always_comb begin
    at_last = (count_q == COORD_W'(TOTAL - 1));
    wrap    = en && at_last;
    count_d = count_q;
    if (en) begin
      count_d = at_last ? '0 : count_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count      = count_q;
  assign count_next = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - free-running VGA raster timing generator
// Purpose: produces raster coordinates, sync pulses, blanking flags,
//          line/frame markers and a completed-frame counter.
// Ports:
//   pclk, rst_n   pixel clock and asynchronous active-low reset
//   en            count enable; low freezes everything, markers forced 0
//   hcount        current pixel column
//   vcount        current line
//   hsync, vsync  sync pulses, asserted level = SYNC_POL
//   hblnk, vblnk  horizontal / vertical blanking
//   line_start    pulse when the raster arrives at hcount == 0
//   frame_start   pulse when the raster arrives at (0,0)
//   frame_cnt     completed frames, modulo 2^16
module vga_timing_gen #(
  parameter int H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int H_FP     = vga_pkg::H_FP,
  parameter int H_SYNC   = vga_pkg::H_SYNC,
  parameter int H_BP     = vga_pkg::H_BP,
  parameter int V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int V_FP     = vga_pkg::V_FP,
  parameter int V_SYNC   = vga_pkg::V_SYNC,
  parameter int V_BP     = vga_pkg::V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                        pclk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic [vga_pkg::COORD_W-1:0] hcount,
  output logic [vga_pkg::COORD_W-1:0] vcount,
  output logic                        hsync,
  output logic                        vsync,
  output logic                        hblnk,
  output logic                        vblnk,
  output logic                        line_start,
  output logic                        frame_start,
  output logic [15:0]                 frame_cnt
);

  import vga_pkg::*;

  localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  logic [COORD_W-1:0] h_q;
  logic [COORD_W-1:0] h_next;
  logic [COORD_W-1:0] v_q;
  logic [COORD_W-1:0] v_next;
  logic               h_wrap;
  logic               v_wrap;

  vga_axis_counter #(
    .TOTAL(H_TOT)
  ) u_hcnt (
    .clk       (pclk),
    .rst_n     (rst_n),
    .en        (en),
    .count     (h_q),
    .count_next(h_next),
    .wrap      (h_wrap)
  );

  // The vertical axis only moves on the horizontal wrap, so vsync and vblnk
  // change on the same edge as hcount returns to 0.
  vga_axis_counter #(
    .TOTAL(V_TOT)
  ) u_vcnt (
    .clk       (pclk),
    .rst_n     (rst_n),
    .en        (h_wrap),
    .count     (v_q),
    .count_next(v_next),
    .wrap      (v_wrap)
  );

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        hblnk_q, hblnk_d;
  logic        vblnk_q, vblnk_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Flags decode the counters' next values so that, once registered, they
  // line up with the coordinates registered on the same edge. With en low
  // the next values equal the current ones, so the flags hold naturally.
  always_comb begin
    hsync_d       = in_window(h_next, HS_START, HS_END) ? SYNC_POL : ~SYNC_POL;
    vsync_d       = in_window(v_next, VS_START, VS_END) ? SYNC_POL : ~SYNC_POL;
    hblnk_d       = (h_next >= COORD_W'(H_ACTIVE));
    vblnk_d       = (v_next >= COORD_W'(V_ACTIVE));
    line_start_d  = en && (h_next == '0);
    frame_start_d = en && (h_next == '0) && (v_next == '0);
    // v_wrap is exactly the step onto (0,0), so this lands with frame_start.
    frame_cnt_d   = frame_cnt_q + {15'd0, v_wrap};
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      hblnk_q       <= 1'b0;
      vblnk_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= 16'd0;
    end else begin
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      hblnk_q       <= hblnk_d;
      vblnk_q       <= vblnk_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign hcount      = h_q;
  assign vcount      = v_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign hblnk       = hblnk_q;
  assign vblnk       = vblnk_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
